tcb_score_argmax: RTL and testbench
===================================

// Module: tcb_score_argmax
// PURPOSE
//  Consumer end of the TCB output-layer score bus. Captures N_CLASS packed signed scores when in_valid
//  is asserted, then finds the winning class with a serial compare, one class per cycle.
//  Presents the class index and its score on a valid/ready output handshake.
//  Sits directly after the final dense layer; the layer's ready pulse drives in_valid.
// PARAMETERS
//  N_CLASS     10   number of class scores on the input bus (>=2)
//  DATA_WIDTH  29   bits per score, two's complement
//  IDX_WIDTH   4    width of class index, >= clog2(N_CLASS)
// PORTS
//  clk          in   1                     clock, all logic on rising edge
//  rst          in   1                     synchronous, active-high reset
//  in_valid     in   1                     scores bus valid (may be a 1-cycle pulse)
//  in_ready     out  1                     block can accept scores this cycle
//  scores       in   DATA_WIDTH*N_CLASS    class i at [i*DATA_WIDTH +: DATA_WIDTH]
//  out_valid    out  1                     class_idx/class_score valid
//  out_ready    in   1                     downstream accepts result
//  class_idx    out  IDX_WIDTH             index of the max score
//  class_score  out  DATA_WIDTH            max score value (signed)
//  busy         out  1                     high in SCAN or DONE
//  overrun      out  1                     sticky: an in_valid was dropped
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1 (comb from state), out_valid=0, class_idx=0, class_score=0, busy=0,
//   overrun=0, internal score register and counter cleared. A reset mid-SCAN or mid-DONE aborts.
//   The partial result is discarded, with no out_valid.
//  FSM states: IDLE, SCAN, DONE. in_ready = (state==IDLE); busy = !in_ready.
//  IDLE: on in_valid, register all scores, best=score[0], best_idx=0, cnt=1, then go to SCAN.
//  SCAN: each cycle, if $signed(score[cnt]) > $signed(best), then best=score[cnt], best_idx=cnt.
//   Strict greater-than: ties keep the lower index. cnt increments.
//   When cnt==N_CLASS-1 is processed, go to DONE. Load class_idx/class_score and set out_valid=1 on the same edge.
//  DONE: out_valid, class_idx and class_score are held stable until out_ready is sampled high.
//   On that edge: out_valid=0, go to IDLE. No same-cycle re-accept; in_ready rises next cycle.
//  Latency: accept edge E produces out_valid high after edge E+N_CLASS-1 (E+9 for default).
//  Throughput: one result per N_CLASS+1 cycles with out_ready held high (11 for default).
//  Drop rule: in_valid while in_ready=0 is ignored (the scan is unaffected) and sets overrun=1.
//   overrun clears only on rst.
//  Compare width: full DATA_WIDTH signed, with no truncation or saturation. Scores are not modified.
//  class_idx/class_score keep their last value after the handshake until the next result loads.
//  Scores are registered at accept; changes on the scores bus after acceptance do not affect the result.
// TESTING
//  T1 reset: assert rst 2 cycles -> out_valid=0, class_idx=0, class_score=0, in_ready=1, overrun=0.
//  T2 basic: scores[i]=i*10, except score[7]=500; 1-cycle in_valid pulse at edge E, out_ready=1 ->
//   out_valid after E+9, class_idx=7, class_score=500; held exactly 1 cycle; in_ready high at E+11.
//  T3 signed/ties: all scores=-177 except score[3]=score[8]=-59 ->
//   class_idx=3, class_score=-59 (29'h1FFFFFC5). All-equal scores -> class_idx=0.
//  T4 backpressure: out_ready=0 for 20 cycles after out_valid -> class_idx/class_score stable and out_valid stays 1.
//   Then out_ready=1 for 1 cycle -> out_valid=0 the next cycle.
//  T5 overrun: second in_valid pulse 4 cycles into SCAN -> first result unchanged and overrun=1.
//   overrun stays 1 after the next accept; it clears only on rst.
//  T6 reset mid-op: rst at SCAN cycle 5 -> no out_valid, state IDLE. A new pulse gives the correct fresh result.

Source files
------------

// File: rtl/tcb_score_argmax.sv
// tcb_score_argmax: captures N_CLASS signed scores and serially finds the max-score class
module tcb_score_argmax #(
    parameter int N_CLASS    = 10,
    parameter int DATA_WIDTH = 29,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*N_CLASS-1:0] scores,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_WIDTH-1:0]          class_idx,
    output logic [DATA_WIDTH-1:0]         class_score,
    output logic                          busy,
    output logic                          overrun
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N_CLASS - 1);
    state_t                        state_q, state_d;
    logic [DATA_WIDTH-1:0]         sc_q [N_CLASS];
    logic [DATA_WIDTH-1:0]         sc_d [N_CLASS];
    logic [IDX_WIDTH-1:0]          cnt_q, cnt_d, best_idx_q, best_idx_d, class_idx_q, class_idx_d;
    logic signed [DATA_WIDTH-1:0]  best_q, best_d, class_score_q, class_score_d, cand;
    logic                          out_valid_q, out_valid_d, overrun_q, overrun_d, take;
    assign in_ready    = (state_q == IDLE);
    assign busy        = !in_ready;
    assign out_valid   = out_valid_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
    assign overrun     = overrun_q;
    // Next-state: capture in IDLE, one strict-greater compare per SCAN cycle, hold result in DONE
    always_comb begin
        state_d       = state_q;
        sc_d          = sc_q;
        cnt_d         = cnt_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        out_valid_d   = out_valid_q;
        overrun_d     = overrun_q | (in_valid && state_q != IDLE);
        cand          = $signed(sc_q[cnt_q]);
        take          = cand > best_q;
        case (state_q)
            IDLE: if (in_valid) begin
                for (int i = 0; i < N_CLASS; i++) sc_d[i] = scores[i*DATA_WIDTH +: DATA_WIDTH];
                best_d     = $signed(scores[DATA_WIDTH-1:0]);
                best_idx_d = '0;
                cnt_d      = IDX_WIDTH'(1);
                state_d    = SCAN;
            end
            SCAN: begin
                best_d     = take ? cand : best_q;
                best_idx_d = take ? cnt_q : best_idx_q;
                cnt_d      = cnt_q + IDX_WIDTH'(1);
                if (cnt_q == LAST) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    class_idx_d   = take ? cnt_q : best_idx_q;
                    class_score_d = take ? cand : best_q;
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sc_q          <= '{default: '0};
            cnt_q         <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sc_q          <= sc_d;
            cnt_q         <= cnt_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
        end
    end
endmodule

// File: tb/tb_tcb_score_argmax.sv
// tb_tcb_score_argmax: directed self-checking bench for tcb_score_argmax
module tb_tcb_score_argmax;
    localparam int N = 10;
    localparam int W = 29;
    logic           clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [W*N-1:0] scores = '0;
    logic           in_ready, out_valid, busy, overrun;
    logic [3:0]     class_idx;
    logic [W-1:0]   class_score;
    int             checks = 0, failures = 0;

    tcb_score_argmax #(.N_CLASS(N), .DATA_WIDTH(W), .IDX_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .scores(scores),
        .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx),
        .class_score(class_score), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) scores[i*W +: W] = v;
    endtask

    task automatic set_one(input int i, input logic [W-1:0] v);
        scores[i*W +: W] = v;
    endtask

    // Starts at a negedge: pulse in_valid, wait for out_valid, capture, advance one more negedge
    task automatic run(output logic [3:0] idx, output logic [W-1:0] sc, output int n);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        idx = class_idx;
        sc  = class_score;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (class_idx !== 4'd0) begin failures++; $display("FAIL reset_class_idx got=%0d exp=0", class_idx); end
        checks++; if (class_score !== '0) begin failures++; $display("FAIL reset_class_score got=%h exp=0", class_score); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic;
        logic [3:0] idx; logic [W-1:0] sc; int n;
        out_ready = 1;
        for (int i = 0; i < N; i++) set_one(i, W'(i * 10));
        set_one(7, W'(500));
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_busy got in_ready=%b busy=%b exp 0/1", in_ready, busy); end
        set_all(W'(1000));
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", n); end
        checks++; if (class_idx !== 4'd7) begin failures++; $display("FAIL basic_idx got=%0d exp=7", class_idx); end
        checks++; if (class_score !== W'(500)) begin failures++; $display("FAIL basic_score got=%0d exp=500", class_score); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_e11 got=%b exp=1", in_ready); end
        checks++; if (class_idx !== 4'd7 || class_score !== W'(500)) begin failures++; $display("FAIL basic_hold got idx=%0d score=%0d exp 7/500", class_idx, class_score); end
    endtask

    task automatic test_signed;
        logic [3:0] idx; logic [W-1:0] sc; int n;
        set_all(W'(-177));
        set_one(3, W'(-59));
        set_one(8, W'(-59));
        run(idx, sc, n);
        checks++; if (idx !== 4'd3) begin failures++; $display("FAIL signed_tie_idx got=%0d exp=3", idx); end
        checks++; if (sc !== 29'h1FFFFFC5) begin failures++; $display("FAIL signed_tie_score got=%h exp=1fffffc5", sc); end
        set_all(W'(42));
        run(idx, sc, n);
        checks++; if (idx !== 4'd0 || sc !== W'(42)) begin failures++; $display("FAIL all_equal got idx=%0d score=%0d exp 0/42", idx, sc); end
        set_all('0);
        set_one(0, 29'h10000000);
        set_one(9, 29'h0FFFFFFF);
        run(idx, sc, n);
        checks++; if (idx !== 4'd9 || sc !== 29'h0FFFFFFF) begin failures++; $display("FAIL extreme_last got idx=%0d score=%h exp 9/0fffffff", idx, sc); end
        set_all(29'h1FFFFFFF);
        set_one(0, W'(5));
        run(idx, sc, n);
        checks++; if (idx !== 4'd0 || sc !== W'(5)) begin failures++; $display("FAIL first_wins got idx=%0d score=%0d exp 0/5", idx, sc); end
    endtask

    task automatic test_backpressure;
        logic [3:0] idx; logic [W-1:0] sc; int n;
        for (int i = 0; i < N; i++) set_one(i, W'(i * 3));
        set_one(5, W'(12345));
        out_ready = 0;
        run(idx, sc, n);
        checks++; if (idx !== 4'd5 || sc !== W'(12345)) begin failures++; $display("FAIL bp_result got idx=%0d score=%0d exp 5/12345", idx, sc); end
        for (int c = 0; c < 19; c++) begin
            checks++;
            if (out_valid !== 1'b1 || class_idx !== 4'd5 || class_score !== W'(12345) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got valid=%b idx=%0d score=%0d in_ready=%b exp 1/5/12345/0", c, out_valid, class_idx, class_score, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
        @(negedge clk);
        checks++; if (class_idx !== 4'd5 || class_score !== W'(12345)) begin failures++; $display("FAIL bp_after_hold got idx=%0d score=%0d exp 5/12345", class_idx, class_score); end
        out_ready = 1;
    endtask

    task automatic test_back_to_back;
        logic [3:0] idx; logic [W-1:0] sc; int n;
        set_all(W'(-1));
        set_one(2, W'(8));
        run(idx, sc, n);
        checks++; if (idx !== 4'd2 || sc !== W'(8)) begin failures++; $display("FAIL b2b_first got idx=%0d score=%0d exp 2/8", idx, sc); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        set_one(2, W'(-1));
        set_one(9, W'(3));
        run(idx, sc, n);
        checks++; if (idx !== 4'd9 || sc !== W'(3) || n !== 9) begin failures++; $display("FAIL b2b_second got idx=%0d score=%0d lat=%0d exp 9/3/9", idx, sc, n); end
    endtask

    task automatic test_overrun;
        logic [3:0] idx; logic [W-1:0] sc; int n;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_initial got=%b exp=0", overrun); end
        set_all(W'(1));
        set_one(2, W'(77));
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        set_all(W'(0));
        set_one(6, W'(9999));
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (class_idx !== 4'd2 || class_score !== W'(77)) begin failures++; $display("FAIL ovr_first_result got idx=%0d score=%0d exp 2/77", class_idx, class_score); end
        @(negedge clk);
        run(idx, sc, n);
        checks++; if (idx !== 4'd6 || sc !== W'(9999)) begin failures++; $display("FAIL ovr_next_result got idx=%0d score=%0d exp 6/9999", idx, sc); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] idx; logic [W-1:0] sc; int n; int seen;
        set_all(W'(10));
        set_one(1, W'(20));
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_abort got valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
        checks++; if (overrun !== 1'b0 || class_idx !== 4'd0 || class_score !== '0) begin failures++; $display("FAIL mid_cleared got ovr=%b idx=%0d score=%0d exp 0/0/0", overrun, class_idx, class_score); end
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_valid got=%0d exp=0", seen); end
        set_all(W'(-100));
        set_one(4, W'(-3));
        run(idx, sc, n);
        checks++; if (idx !== 4'd4 || sc !== W'(-3) || n !== 9) begin failures++; $display("FAIL mid_fresh got idx=%0d score=%h lat=%0d exp 4/1ffffffd/9", idx, sc, n); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_signed;
        test_backpressure;
        test_back_to_back;
        test_overrun;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
